// File: rtl/fft_sched_if.sv
// fft_sched_if: sample-in, core-control and sample-out signals of the FFT frame scheduler.
interface fft_sched_if #(
  parameter int ADDR_W = 5,
  parameter int FCNT_W = 16
);
  logic              in_valid, in_ready, wr_en, wr_bank;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic              fft_start, core_bank, fft_done, rd_bank;
  logic              out_valid, out_ready, out_last;
  logic [FCNT_W-1:0] frame_cnt;
  logic              err_timeout;
  modport master (
    input  in_valid, fft_done, out_ready,
    output in_ready, wr_en, wr_bank, wr_addr, fft_start, core_bank,
           rd_bank, rd_addr, out_valid, out_last, frame_cnt, err_timeout
  );
  modport slave (
    output in_valid, fft_done, out_ready,
    input  in_ready, wr_en, wr_bank, wr_addr, fft_start, core_bank,
           rd_bank, rd_addr, out_valid, out_last, frame_cnt, err_timeout
  );
endinterface

// File: rtl/fft_frame_scheduler.sv
// fft_frame_scheduler: ping-pong bank sequencer around a 32-point DIT FFT core
// (bit-reversed fill, start/done launch with timeout, natural-order drain).
module fft_frame_scheduler #(
  parameter int N_POINTS = 32,
  parameter int ADDR_W   = 5,
  parameter int TIMEOUT  = 16,
  parameter int FCNT_W   = 16
) (
  input  logic       clk,
  input  logic       rst,
  fft_sched_if.master bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, BUSY} bank_e;
  typedef enum logic [1:0] {IDLE, START, WAIT, DRAIN} core_e;
  bank_e             bank_q [2];
  bank_e             bank_d [2];
  core_e             state_q, state_d;
  logic              run_q;
  logic              wr_bank_q, wr_bank_d, core_bank_q, core_bank_d, err_q, err_d;
  logic [ADDR_W-1:0] widx_q, widx_d, ridx_q, ridx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              in_ready, wr_en, last_wr, rd_hs, last_rd, timeout;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      run_q       <= 1'b0;
      bank_q      <= '{EMPTY, EMPTY};
      state_q     <= IDLE;
      wr_bank_q   <= 1'b0;
      core_bank_q <= 1'b0;
      err_q       <= 1'b0;
      widx_q      <= '0;
      ridx_q      <= '0;
      cnt_q       <= '0;
      fcnt_q      <= '0;
    end else begin
      run_q       <= 1'b1;
      bank_q      <= bank_d;
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      core_bank_q <= core_bank_d;
      err_q       <= err_d;
      widx_q      <= widx_d;
      ridx_q      <= ridx_d;
      cnt_q       <= cnt_d;
      fcnt_q      <= fcnt_d;
    end
  // Write side and core side never touch the same bank in one cycle, so both updates apply.
  always_comb begin
    bank_d      = bank_q;
    state_d     = state_q;
    wr_bank_d   = wr_bank_q;
    core_bank_d = core_bank_q;
    err_d       = err_q;
    widx_d      = widx_q;
    ridx_d      = ridx_q;
    cnt_d       = cnt_q;
    fcnt_d      = fcnt_q;
    if (wr_en) begin
      bank_d[wr_bank_q] = last_wr ? FULL : FILLING;
      widx_d            = last_wr ? '0 : widx_q + 1'b1;
      wr_bank_d         = wr_bank_q ^ last_wr;
    end
    case (state_q)
      IDLE:
        if (bank_q[0] == FULL || bank_q[1] == FULL) begin
          state_d     = START;
          core_bank_d = (bank_q[0] == FULL && bank_q[1] == FULL) ? ~wr_bank_q : (bank_q[1] == FULL);
        end
      START: begin
        state_d             = WAIT;
        bank_d[core_bank_q] = BUSY;
        cnt_d               = CW'(1);
      end
      WAIT:
        if (bus.fft_done) begin
          state_d = DRAIN;
          ridx_d  = '0;
        end else if (timeout) begin
          state_d             = IDLE;
          err_d               = 1'b1;
          bank_d[core_bank_q] = EMPTY;
        end else
          cnt_d = cnt_q + 1'b1;
      DRAIN:
        if (rd_hs) begin
          ridx_d = last_rd ? '0 : ridx_q + 1'b1;
          if (last_rd) begin
            state_d             = IDLE;
            bank_d[core_bank_q] = EMPTY;
            fcnt_d              = fcnt_q + 1'b1;
          end
        end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    in_ready = run_q && (bank_q[wr_bank_q] == EMPTY || bank_q[wr_bank_q] == FILLING);
    wr_en    = bus.in_valid && in_ready;
    last_wr  = widx_q == ADDR_W'(N_POINTS - 1);
    rd_hs    = state_q == DRAIN && bus.out_ready;
    last_rd  = ridx_q == ADDR_W'(N_POINTS - 1);
    timeout  = cnt_q == CW'(TIMEOUT - 1);
  end
  for (genvar i = 0; i < ADDR_W; i++) begin : g_bitrev
    assign bus.wr_addr[i] = widx_q[ADDR_W-1-i];
  end
  assign bus.in_ready    = in_ready;
  assign bus.wr_en       = wr_en;
  assign bus.wr_bank     = wr_bank_q;
  assign bus.fft_start   = state_q == START;
  assign bus.core_bank   = core_bank_q;
  assign bus.rd_bank     = core_bank_q;
  assign bus.rd_addr     = ridx_q;
  assign bus.out_valid   = state_q == DRAIN;
  assign bus.out_last    = state_q == DRAIN && last_rd;
  assign bus.frame_cnt   = fcnt_q;
  assign bus.err_timeout = err_q;
endmodule

// File: tb/tb_fft_frame_scheduler.sv
// tb_fft_frame_scheduler: directed scenario tasks for fft_frame_scheduler; a second
// instance with a 2-bit frame counter shares all inputs to observe counter wrap.
module tb_fft_frame_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  fft_sched_if #(.ADDR_W(5), .FCNT_W(16)) b1 ();
  fft_sched_if #(.ADDR_W(5), .FCNT_W(2))  b2 ();
  fft_frame_scheduler #(.N_POINTS(32), .ADDR_W(5), .TIMEOUT(16), .FCNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(b1.master));
  fft_frame_scheduler #(.N_POINTS(32), .ADDR_W(5), .TIMEOUT(16), .FCNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(b2.master));
  assign b2.in_valid  = b1.in_valid;
  assign b2.fft_done  = b1.fft_done;
  assign b2.out_ready = b1.out_ready;
  int n_cmp = 0;
  int n_bad = 0;
  int br [32] = '{0, 16, 8, 24, 4, 20, 12, 28, 2, 18, 10, 26, 6, 22, 14, 30,
                  1, 17, 9, 25, 5, 21, 13, 29, 3, 19, 11, 27, 7, 23, 15, 31};
  bit auto_done = 1'b0;
  int cnt_dn = 0;
  // Core stand-in: pulses fft_done five cycles after each observed start pulse.
  initial forever begin
    @(posedge clk); #1;
    if (auto_done) begin
      b1.fft_done = 1'b0;
      if (cnt_dn > 0) begin
        cnt_dn--;
        if (cnt_dn == 0) b1.fft_done = 1'b1;
      end
      if (b1.fft_start) cnt_dn = 5;
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic tick;
    @(posedge clk); #1;
    b1.in_valid = 1'b0;
    if (!auto_done) b1.fft_done = 1'b0;
  endtask
  task automatic do_reset;
    auto_done = 1'b0;
    b1.fft_done = 1'b0;
    cnt_dn = 0;
    rst = 1'b1;
    b1.out_ready = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    tick;
  endtask
  task automatic send_frame(input bit bank);
    int i = 0;
    int g = 0;
    while (i < 32 && g < 200) begin
      tick;
      g++;
      b1.in_valid = 1'b1;
      #1;
      if (b1.wr_en) begin
        n_cmp++;
        if (b1.wr_addr !== 5'(br[i]) || b1.wr_bank !== bank) begin
          n_bad++;
          $display("FAIL send_frame beat %0d: wr_addr=%0d wr_bank=%0b, want %0d/%0b", i, b1.wr_addr, b1.wr_bank, br[i], bank);
        end
        i++;
      end
    end
    n_cmp++;
    if (i != 32) begin
      n_bad++;
      $display("FAIL send_frame accepted: got %0d samples, want 32", i);
    end
  endtask
  task automatic drain_frame(input bit bank);
    int k = 0;
    int g = 0;
    b1.out_ready = 1'b1;
    while (!b1.out_valid && g < 64) begin
      tick;
      g++;
    end
    while (k < 32 && g < 200) begin
      n_cmp++;
      if (b1.out_valid !== 1'b1 || b1.rd_addr !== 5'(k) || b1.rd_bank !== bank || b1.out_last !== (k == 31)) begin
        n_bad++;
        $display("FAIL drain beat %0d: valid=%0b rd_addr=%0d rd_bank=%0b last=%0b, want 1/%0d/%0b/%0b", k, b1.out_valid, b1.rd_addr, b1.rd_bank, b1.out_last, k, bank, k == 31);
      end
      k++;
      tick;
      g++;
    end
    n_cmp++;
    if (b1.out_valid !== 1'b0 || k != 32) begin
      n_bad++;
      $display("FAIL drain end: out_valid=%0b beats=%0d, want 0/32", b1.out_valid, k);
    end
  endtask
  task automatic test_reset;
    #1;
    rst = 1'b1;
    b1.in_valid = 1'b0;
    b1.out_ready = 1'b0;
    b1.fft_done = 1'b0;
    tick;
    n_cmp++;
    if ({b1.in_ready, b1.out_valid, b1.fft_start, b1.err_timeout, b1.wr_bank} !== 5'b0 || b1.frame_cnt !== 16'd0 || b1.wr_addr !== 5'd0 || b1.rd_addr !== 5'd0) begin
      n_bad++;
      $display("FAIL reset outputs: in_ready=%0b out_valid=%0b start=%0b err=%0b cnt=%0d, want all 0", b1.in_ready, b1.out_valid, b1.fft_start, b1.err_timeout, b1.frame_cnt);
    end
    rst = 1'b0;
    tick;
    n_cmp++;
    if (b1.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset release in_ready: got %0b, want 1", b1.in_ready);
    end
  endtask
  task automatic test_single_frame;
    auto_done = 1'b1;
    send_frame(1'b0);
    tick;
    n_cmp++;
    if (b1.fft_start !== 1'b0) begin
      n_bad++;
      $display("FAIL single start t+1: got %0b, want 0", b1.fft_start);
    end
    tick;
    n_cmp++;
    if (b1.fft_start !== 1'b1 || b1.core_bank !== 1'b0) begin
      n_bad++;
      $display("FAIL single start t+2: start=%0b core_bank=%0b, want 1/0", b1.fft_start, b1.core_bank);
    end
    for (int i = 0; i < 5; i++) begin
      tick;
      n_cmp++;
      if (b1.out_valid !== 1'b0 || b1.fft_start !== 1'b0) begin
        n_bad++;
        $display("FAIL single wait %0d: out_valid=%0b start=%0b, want 0/0", i, b1.out_valid, b1.fft_start);
      end
    end
    tick;
    n_cmp++;
    if (b1.out_valid !== 1'b1 || b1.rd_addr !== 5'd0) begin
      n_bad++;
      $display("FAIL single drain entry: out_valid=%0b rd_addr=%0d, want 1/0", b1.out_valid, b1.rd_addr);
    end
    drain_frame(1'b0);
    n_cmp++;
    if (b1.frame_cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL single frame_cnt: got %0d, want 1", b1.frame_cnt);
    end
  endtask
  task automatic test_back_to_back;
    int sent = 0;
    int stall = 0;
    int early = 0;
    int starts = 0;
    int g = 0;
    do_reset;
    auto_done = 1'b1;
    b1.out_ready = 1'b1;
    while (b1.frame_cnt != 16'd3 && g < 400) begin
      tick;
      g++;
      b1.in_valid = sent < 96;
      #1;
      if (b1.wr_en) begin
        n_cmp++;
        if (b1.wr_bank !== 1'((sent / 32) % 2)) begin
          n_bad++;
          $display("FAIL b2b wr_bank sample %0d: got %0b, want %0b", sent, b1.wr_bank, (sent / 32) % 2);
        end
        sent++;
      end else if (sent > 0 && sent < 96) begin
        stall++;
        if (sent < 64) early++;
      end
      if (b1.fft_start) begin
        n_cmp++;
        if (b1.core_bank !== 1'(starts % 2)) begin
          n_bad++;
          $display("FAIL b2b core_bank start %0d: got %0b, want %0b", starts, b1.core_bank, starts % 2);
        end
        starts++;
      end
    end
    n_cmp++;
    if (sent != 96 || early != 0 || stall != 7 || starts != 3 || b1.frame_cnt !== 16'd3) begin
      n_bad++;
      $display("FAIL b2b totals: sent=%0d early_stall=%0d stall=%0d starts=%0d frame_cnt=%0d, want 96/0/7/3/3", sent, early, stall, starts, b1.frame_cnt);
    end
  endtask
  task automatic test_backpressure;
    int sent = 0;
    int stall = 0;
    int beat = 0;
    int k = 0;
    int g = 0;
    do_reset;
    auto_done = 1'b1;
    while (sent < 65 && g < 300) begin
      tick;
      g++;
      b1.in_valid = 1'b1;
      if (b1.out_valid && beat < 32) begin
        b1.out_ready = (k % 4 == 0) || (k % 4 == 3);
        k++;
      end else
        b1.out_ready = 1'b0;
      #1;
      if (b1.out_valid && beat < 32) begin
        n_cmp++;
        if (b1.rd_addr !== 5'(beat) || b1.out_last !== (beat == 31)) begin
          n_bad++;
          $display("FAIL bp beat %0d: rd_addr=%0d last=%0b, want %0d/%0b", beat, b1.rd_addr, b1.out_last, beat, beat == 31);
        end
        if (b1.out_ready) beat++;
      end
      if (b1.wr_en) sent++;
      else if (sent > 0) stall++;
    end
    n_cmp++;
    if (beat != 32 || stall != 39 || sent != 65) begin
      n_bad++;
      $display("FAIL bp totals: beats=%0d stall=%0d sent=%0d, want 32/39/65", beat, stall, sent);
    end
  endtask
  task automatic test_timeout;
    int g = 0;
    do_reset;
    send_frame(1'b0);
    while (!b1.fft_start && g < 10) begin
      tick;
      g++;
    end
    n_cmp++;
    if (b1.fft_start !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout start: got %0b, want 1", b1.fft_start);
    end
    for (int i = 1; i < 16; i++) begin
      tick;
      n_cmp++;
      if (b1.err_timeout !== 1'b0 || b1.out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL timeout early cycle %0d: err=%0b out_valid=%0b, want 0/0", i, b1.err_timeout, b1.out_valid);
      end
    end
    tick;
    n_cmp++;
    if (b1.err_timeout !== 1'b1 || b1.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout flag: err=%0b out_valid=%0b, want 1/0", b1.err_timeout, b1.out_valid);
    end
    b1.fft_done = 1'b1;
    tick;
    tick;
    n_cmp++;
    if (b1.out_valid !== 1'b0 || b1.fft_start !== 1'b0 || b1.frame_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL stray done idle: out_valid=%0b start=%0b frame_cnt=%0d, want 0/0/0", b1.out_valid, b1.fft_start, b1.frame_cnt);
    end
    send_frame(1'b1);
    g = 0;
    while (!b1.fft_start && g < 10) begin
      tick;
      g++;
    end
    n_cmp++;
    if (b1.fft_start !== 1'b1 || b1.core_bank !== 1'b1) begin
      n_bad++;
      $display("FAIL post-timeout start: start=%0b core_bank=%0b, want 1/1", b1.fft_start, b1.core_bank);
    end
    tick;
    tick;
    tick;
    b1.fft_done = 1'b1;
    tick;
    b1.out_ready = 1'b1;
    for (int k = 0; k < 32; k++) begin
      if (k == 5) b1.fft_done = 1'b1;
      n_cmp++;
      if (b1.out_valid !== 1'b1 || b1.rd_addr !== 5'(k) || b1.rd_bank !== 1'b1) begin
        n_bad++;
        $display("FAIL post-timeout drain %0d: valid=%0b rd_addr=%0d rd_bank=%0b, want 1/%0d/1", k, b1.out_valid, b1.rd_addr, b1.rd_bank, k);
      end
      tick;
    end
    n_cmp++;
    if (b1.out_valid !== 1'b0 || b1.frame_cnt !== 16'd1 || b1.err_timeout !== 1'b1 || b1.in_ready !== 1'b1 || b1.wr_bank !== 1'b0) begin
      n_bad++;
      $display("FAIL post-timeout end: valid=%0b frame_cnt=%0d err=%0b in_ready=%0b wr_bank=%0b, want 0/1/1/1/0", b1.out_valid, b1.frame_cnt, b1.err_timeout, b1.in_ready, b1.wr_bank);
    end
  endtask
  task automatic test_reset_mid;
    int g = 0;
    auto_done = 1'b1;
    send_frame(1'b0);
    b1.out_ready = 1'b1;
    while (!(b1.out_valid && b1.rd_addr == 5'd10) && g < 100) begin
      tick;
      g++;
    end
    n_cmp++;
    if (b1.out_valid !== 1'b1 || b1.rd_addr !== 5'd10 || b1.frame_cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL mid-reset setup: valid=%0b rd_addr=%0d frame_cnt=%0d, want 1/10/1", b1.out_valid, b1.rd_addr, b1.frame_cnt);
    end
    auto_done = 1'b0;
    b1.fft_done = 1'b0;
    cnt_dn = 0;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({b1.out_valid, b1.in_ready, b1.fft_start, b1.err_timeout, b1.wr_bank, b1.out_last} !== 6'b0 || b1.rd_addr !== 5'd0 || b1.frame_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL mid-reset outputs: valid=%0b in_ready=%0b err=%0b rd_addr=%0d frame_cnt=%0d, want all 0", b1.out_valid, b1.in_ready, b1.err_timeout, b1.rd_addr, b1.frame_cnt);
    end
    tick;
    rst = 1'b0;
    tick;
    b1.in_valid = 1'b1;
    #1;
    n_cmp++;
    if (b1.wr_en !== 1'b1 || b1.wr_bank !== 1'b0 || b1.wr_addr !== 5'd0) begin
      n_bad++;
      $display("FAIL post-reset write: wr_en=%0b wr_bank=%0b wr_addr=%0d, want 1/0/0", b1.wr_en, b1.wr_bank, b1.wr_addr);
    end
    tick;
  endtask
  task automatic test_wrap;
    int sent = 0;
    int g = 0;
    do_reset;
    auto_done = 1'b1;
    b1.out_ready = 1'b1;
    while (b1.frame_cnt != 16'd5 && g < 1000) begin
      tick;
      g++;
      b1.in_valid = sent < 160;
      #1;
      if (b1.wr_en) sent++;
    end
    n_cmp++;
    if (b1.frame_cnt !== 16'd5 || b2.frame_cnt !== 2'd1) begin
      n_bad++;
      $display("FAIL wrap: frame_cnt=%0d narrow=%0d, want 5/1", b1.frame_cnt, b2.frame_cnt);
    end
  endtask
  initial begin
    b1.in_valid = 1'b0;
    b1.out_ready = 1'b0;
    b1.fft_done = 1'b0;
    test_reset;
    test_single_frame;
    test_back_to_back;
    test_backpressure;
    test_timeout;
    test_reset_mid;
    test_wrap;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fft_frame_scheduler.md
Name: fft_frame_scheduler

Overview:
- Frame-level sequencer in front of the 32-point DIT FFT core.
- Accepts a serial sample stream into a two-bank (ping-pong) input memory, writing each sample at its bit-reversed address.
- Launches the core's stage controller on each full bank with a one-cycle start pulse, then waits for its done indication.
- Streams the finished bank out in natural order under a valid/ready handshake, then frees the bank for refill.

Parameters:
- N_POINTS, 32, samples per frame; power of two.
- ADDR_W, 5, log2(N_POINTS).
- TIMEOUT, 16, max cycles allowed from start pulse to fft_done before abort.
- FCNT_W, 16, width of completed-frame counter.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, upstream sample present.
- in_ready, output, 1, scheduler can accept a sample this cycle.
- wr_en, output, 1, write strobe to input memory (= in_valid & in_ready).
- wr_bank, output, 1, bank being filled.
- wr_addr, output, ADDR_W, bit-reversed write address.
- fft_start, output, 1, one-cycle launch pulse to the FFT stage controller.
- core_bank, output, 1, bank the core operates on in place.
- fft_done, input, 1, single-cycle completion pulse from the core.
- rd_bank, output, 1, bank being drained.
- rd_addr, output, ADDR_W, natural-order read address (combinational-read memory).
- out_valid, output, 1, output sample valid.
- out_ready, input, 1, downstream accepts sample.
- out_last, output, 1, high with out_valid on index N_POINTS-1.
- frame_cnt, output, FCNT_W, frames fully drained; wraps.
- err_timeout, output, 1, sticky; set on core timeout.

Behaviour:
- Reset (async, rst=1):
  - Both banks EMPTY; wr_bank=0; write index=0.
  - Core FSM in IDLE.
  - All outputs 0: in_ready=0 during reset, 1 from the first cycle after release.
  - frame_cnt=0; err_timeout=0.
  - Reset mid-frame discards all partial and full frames.
- Bank state per bank: EMPTY -> FILLING -> FULL -> BUSY -> EMPTY.
- Write side:
  - in_ready=1 iff bank[wr_bank] is EMPTY or FILLING.
  - On wr_en: wr_addr = bitrev(write index); index increments.
  - At index N_POINTS-1 accepted: bank becomes FULL, wr_bank toggles, index clears.
  - in_ready in the next cycle reflects the new bank's state.
- Core FSM states: IDLE, START, WAIT, DRAIN.
  - IDLE: if any bank is FULL, go to START and select core_bank; if both are FULL, pick the one filled first (the bank != wr_bank).
  - START: fft_start=1 for exactly one cycle; bank marked BUSY; go to WAIT.
  - WAIT: a cycle counter runs. On fft_done go to DRAIN with rd_bank=core_bank and rd_addr=0. If the counter reaches TIMEOUT without fft_done: set err_timeout, mark bank EMPTY, go to IDLE; frame is dropped and frame_cnt is unchanged.
  - DRAIN: out_valid=1. rd_addr advances only on out_valid & out_ready; it holds while stalled. On the handshake at rd_addr=N_POINTS-1 (out_last=1): bank becomes EMPTY, frame_cnt increments, go to IDLE. out_valid drops the following cycle.
- Minimum latency: last input accepted at cycle t -> fft_start at t+2 (FULL registered at t+1, START at t+2).
- Simultaneous events:
  - Release of bank X and completion of fill on bank Y in the same cycle are both honoured.
  - A bank released by DRAIN is writable the cycle after release.
  - fft_done outside WAIT is ignored.
- Throughput: the write side never stalls while the other bank is EMPTY; two frames may be held (one FULL, one BUSY).
- frame_cnt wraps from 2^FCNT_W-1 to 0.
- err_timeout clears only on reset.

Test Plan:
- Single frame: 32 samples valued 0..31 streamed back-to-back -> wr_addr sequence 0,16,8,24,4,...,31; one fft_start 2 cycles after the last write; fft_done after 5 cycles -> 32 out beats rd_addr 0..31, out_last on the 32nd, frame_cnt=1.
- Back-to-back frames: 96 continuous samples with core and out_ready always ready -> in_ready stays 1 across frames 1–2; banks alternate 0,1,0; frame_cnt=3.
- Backpressure: out_ready toggling 1,0,0,1 during DRAIN -> rd_addr holds on stalls, no beat lost/duplicated; both banks FULL/BUSY -> in_ready=0 until first release, then 1 next cycle.
- Timeout: fft_done never asserted -> err_timeout=1 exactly TIMEOUT cycles after fft_start; no out_valid; bank EMPTY; next frame processes normally with err_timeout still 1.
- Reset mid-operation: rst during DRAIN at rd_addr=10 -> all outputs 0 immediately, frame_cnt=0; post-reset frame starts at wr_bank 0, wr_addr 0.
- Stray fft_done in IDLE/DRAIN and frame_cnt wrap (FCNT_W=2, 5 frames) -> no state change from stray pulse; frame_cnt reads 1.
